sva_impl_monitor: RTL

Synthesizable hardware monitor that evaluates a single implication property, `antecedent |-> ##DELAY consequent`, with an optional `disable iff` term. It produces registered pass/fail/vacuous pulses, saturating pass and fail counters, and a first-failure timestamp. It sits directly downstream of the signals an SVA implication would watch. This gives emulation/FPGA builds and simulators without assertion support the same verdicts that `|->` (DELAY=0) and `|=>` (DELAY=1) give in simulation.

---
 rtl/sva_impl_monitor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sva_impl_monitor.sv
// rtl/sva_impl_monitor.sv - hardware evaluator for antecedent |-> ##DELAY consequent with disable iff
module sva_impl_monitor #(
    parameter int DELAY  = 1,
    parameter int CNT_W  = 16,
    parameter int TIME_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic              disable_iff,
    input  logic              antecedent,
    input  logic              consequent,
    output logic              pass_o,
    output logic              fail_o,
    output logic              vacuous_o,
    output logic              pend_o,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              first_fail_valid,
    output logic [TIME_W-1:0] first_fail_time
);

    logic              launch;
    logic              check_due;
    logic              pass_hit;
    logic              fail_hit;
    logic              vac_hit;
    logic [TIME_W-1:0] stamp;

    // A launch needs the enable, a true antecedent and no disable at the same edge.
    assign launch = en & antecedent & ~disable_iff;

    generate
        if (DELAY == 0) begin : g_overlap
            // Overlapping implication: the attempt is checked at its own launch edge.
            assign check_due = launch;
            assign pend_o    = 1'b0;
        end else begin : g_delayed
            // Bit i holds an attempt launched i+1 edges ago; the top bit is due now.
            logic [DELAY-1:0] age_sr;

            assign check_due = age_sr[DELAY-1] & ~disable_iff;
            assign pend_o    = |age_sr;

            // Age pending attempts; a disable or clear wipes every one of them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    age_sr <= '0;
                end else if (clear || disable_iff) begin
                    age_sr <= '0;
                end else begin
                    age_sr <= (age_sr << 1) | DELAY'(launch);
                end
            end
        end
    endgenerate

    // Results for this edge; clear suppresses every pulse at its edge.
    assign pass_hit = ~clear & check_due & consequent;
    assign fail_hit = ~clear & check_due & ~consequent;
    assign vac_hit  = ~clear & ~disable_iff & ~(en & antecedent);

    // Register the one-cycle verdict pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_o    <= 1'b0;
            fail_o    <= 1'b0;
            vacuous_o <= 1'b0;
        end else begin
            pass_o    <= pass_hit;
            fail_o    <= fail_hit;
            vacuous_o <= vac_hit;
        end
    end

    // Saturating pass counter; holds at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
        end else if (clear) begin
            pass_cnt <= '0;
        end else if (pass_hit && (pass_cnt != {CNT_W{1'b1}})) begin
            pass_cnt <= pass_cnt + CNT_W'(1);
        end
    end

    // Saturating fail counter; holds at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt <= '0;
        end else if (clear) begin
            fail_cnt <= '0;
        end else if (fail_hit && (fail_cnt != {CNT_W{1'b1}})) begin
            fail_cnt <= fail_cnt + CNT_W'(1);
        end
    end

    // Free-running cycle stamp; clear deliberately leaves it running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp <= '0;
        end else begin
            stamp <= stamp + TIME_W'(1);
        end
    end

    // Capture the stamp of the check edge of the first failure only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_valid <= 1'b0;
            first_fail_time  <= '0;
        end else if (clear) begin
            first_fail_valid <= 1'b0;
            first_fail_time  <= '0;
        end else if (fail_hit && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_time  <= stamp;
        end
    end

endmodule
